step_controller: RTL and testbench
==================================

STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to accept a new switch level (range 1..255).
REQ-002 SHALL have parameter RUN_DIV, default 1000: clocks between step pulses in run mode (range 2..65535).
REQ-003 SHALL have one clock and an asynchronous active-low reset, as below.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 step_btn  input  1  raw single-step push button, active-high, asynchronous, bouncy.
REQ-007 run_sw  input  1  raw run/step mode switch; 1 = free-run, 0 = single-step; asynchronous, bouncy.
REQ-008 cpu_continue  input  1  CPU control-unit Continue bit; 0 = halt instruction decoded.
REQ-009 step_en  output  1  one-clock pulse; the CPU commits PC and register-file updates only on clk edges where step_en is high.
REQ-010 halted  output  1  high while in HALT.
REQ-011 state  output  2  current FSM state: IDLE=00, STEP=01, RUN=10, HALT=11.

Function
REQ-012 SHALL pass step_btn and run_sw each through a two-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized input independently: 8-bit counter clears whenever sample equals debounced level; otherwise increments; when it reaches DEBOUNCE_CYCLES, debounced level takes the sample and counter clears.
REQ-014 SHALL detect a step request as a 0->1 transition of debounced step_btn; a held button yields exactly one request.
REQ-015 SHALL register step_en (no combinational path from any input to step_en).
REQ-016 IDLE: cpu_continue=0 -> HALT; else debounced run_sw=1 -> RUN with rate counter cleared; else step request -> STEP; else remain.
REQ-017 STEP: step_en high for exactly this one cycle; next state IDLE.
REQ-018 RUN: 16-bit rate counter counts 0..RUN_DIV-1 and wraps to 0; step_en high for one cycle each time the counter wraps.
REQ-019 RUN: debounced run_sw=0 -> IDLE; step_en low in the transition cycle; step requests ignored in RUN.
REQ-020 RUN or STEP: cpu_continue=0 -> HALT on the next edge; step_en SHALL NOT assert once cpu_continue=0 has been sampled.
REQ-021 HALT: step_en=0, halted=1; all inputs ignored; exit only via reset.
REQ-022 Simultaneous events in IDLE resolve by priority halt > run > step.
REQ-023 Single-step latency: first step_en cycle begins at edge DEBOUNCE_CYCLES+4 counted from the first edge sampling a stable high step_btn (edge 1).
REQ-024 Run latency: first step_en in RUN occurs RUN_DIV clocks after entering RUN; thereafter exactly every RUN_DIV clocks.

Reset
REQ-025 reset_n=0 SHALL immediately force: state=IDLE, step_en=0, halted=0, synchronizers and debounced levels 0, debounce and rate counters 0.
REQ-026 Reset assertion mid-RUN or mid-STEP SHALL abort with no further step_en; a button held through reset release SHALL NOT generate a step request until released and re-pressed (debounced level sampled 0->1 only after release).
REQ-027 Reset release SHALL be synchronous to clk at the consumer side (assume reset_n deasserted away from clk edge; no additional requirement on block).

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=5, cpu_continue=1 unless stated)
REQ-028 Clean press: step_btn 0->1 held 50 clocks -> exactly one step_en pulse, high during cycle starting at edge 8; state 00->01->00.
REQ-029 Bounce: step_btn toggles every 2 clocks for 20 clocks then settles high -> no step_en during bouncing; exactly one pulse after settling, 8 edges after the last transition.
REQ-030 Run mode: run_sw=1 held -> state=10; step_en pulses exactly every 5 clocks, first pulse 5 clocks after entering RUN; run_sw=0 -> state=00, no further pulses.
REQ-031 Halt: in RUN, drive cpu_continue=0 one cycle before a due pulse -> no pulse, state=11, halted=1; subsequent button presses and run_sw toggles -> no step_en.
REQ-032 Priority: in IDLE, run_sw debounced high and step request same cycle -> RUN entered, no STEP pulse; with cpu_continue=0 same cycle -> HALT.
REQ-033 Reset: assert reset_n=0 mid-RUN with rate counter at 3 -> step_en=0 and state=00 immediately; after release with run_sw=0, no step_en until a new press.

Source files
------------

// File: rtl/step_controller_if.sv
// Handshake bundle between the CPU front panel/control unit and the step controller.
// The master drives the raw panel inputs and Continue; the slave produces the step strobe and status.
interface step_controller_if;
  logic       step_btn;
  logic       run_sw;
  logic       cpu_continue;
  logic       step_en;
  logic       halted;
  logic [1:0] state;

  modport master (
    output step_btn, run_sw, cpu_continue,
    input  step_en, halted, state
  );

  modport slave (
    input  step_btn, run_sw, cpu_continue,
    output step_en, halted, state
  );
endinterface

// File: rtl/step_controller.sv
// CPU clock-enable generator: debounced single-step button and run switch, free-run rate divider,
// and a sticky HALT entered when the control unit drops Continue.
module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RUN_DIV         = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  step_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_e;

  localparam int unsigned BTN = 0;
  localparam int unsigned SW  = 1;

  localparam logic [7:0]  DB_LIMIT  = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] RATE_LAST = 16'(RUN_DIV - 1);

  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      level_q, level_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic            btn_prev_q, btn_prev_d;
  logic [1:0]      valid_q, valid_d;
  logic            armed_q, armed_d;
  state_e          state_q, state_d;
  logic [15:0]     rate_q, rate_d;
  logic            step_en_q, step_en_d;
  logic            step_req;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sync1_d    = {bus.run_sw, bus.step_btn};
    sync2_d    = sync1_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    btn_prev_d = level_q[BTN];
    valid_d    = {valid_q[0], 1'b1};

    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LIMIT) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end

    // A button held through reset stays disarmed until the synchronized level is seen low once.
    armed_d = armed_q | (valid_q[1] & ~sync2_q[BTN]);
  end

  assign step_req = level_q[BTN] & ~btn_prev_q & armed_q;

  always_comb begin
    state_d   = state_q;
    rate_d    = '0;
    step_en_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.cpu_continue) begin
          state_d = HALT;
        end else if (level_q[SW]) begin
          state_d = RUN;
        end else if (step_req) begin
          state_d   = STEP;
          step_en_d = 1'b1;
        end
      end
      STEP: begin
        state_d = bus.cpu_continue ? IDLE : HALT;
      end
      RUN: begin
        if (!bus.cpu_continue) begin
          state_d = HALT;
        end else if (!level_q[SW]) begin
          state_d = IDLE;
        end else if (rate_q == RATE_LAST) begin
          step_en_d = 1'b1;
        end else begin
          rate_d = rate_q + 16'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      btn_prev_q <= 1'b0;
      valid_q    <= '0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      rate_q     <= '0;
      step_en_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      valid_q    <= valid_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      rate_q     <= rate_d;
      step_en_q  <= step_en_d;
    end
  end

  assign bus.step_en = step_en_q;
  assign bus.halted  = (state_q == HALT);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with DEBOUNCE_CYCLES=4, RUN_DIV=5.
// Outputs are sampled 1 ns after each rising edge; cyc counts those edges.
module tb_step_controller;

  localparam int DB = 4;
  localparam int RD = 5;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  step_controller_if bus ();

  step_controller #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV        (RD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors      = 0;
  int checks      = 0;
  int cyc         = 0;
  int pulses      = 0;
  int first_pulse = -1;
  int last_pulse  = -1;
  int t0          = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.step_en === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_log();
    pulses      = 0;
    first_pulse = -1;
    last_pulse  = -1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.step_btn     = 1'b0;
    bus.run_sw       = 1'b0;
    bus.cpu_continue = 1'b1;
    ticks(3);
    #3 reset_n = 1'b1;
    ticks(6);
  endtask

  initial begin
    bus.step_btn     = 1'b0;
    bus.run_sw       = 1'b0;
    bus.cpu_continue = 1'b1;
    reset_n          = 1'b0;
    ticks(2);
    check("rst_state",   32'(bus.state),   32'd0);
    check("rst_step_en", 32'(bus.step_en), 32'd0);
    check("rst_halted",  32'(bus.halted),  32'd0);
    #3 reset_n = 1'b1;
    ticks(6);

    // Clean press held 50 clocks: one pulse at edge 8, IDLE->STEP->IDLE.
    clear_log();
    t0 = cyc;
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 7) check("press_pre_state",  32'(bus.state), 32'd0);
      if (i == 8) check("press_step_state", 32'(bus.state), 32'd1);
      if (i == 9) check("press_back_state", 32'(bus.state), 32'd0);
    end
    check("press_count", 32'(pulses), 32'd1);
    check("press_edge",  32'(first_pulse - t0), 32'd8);
    bus.step_btn = 1'b0;
    ticks(20);

    // Bounce every 2 clocks for 20 clocks, then settle high.
    clear_log();
    for (int i = 0; i < 10; i++) begin
      bus.step_btn = ~bus.step_btn;
      ticks(2);
    end
    check("bounce_quiet", 32'(pulses), 32'd0);
    bus.step_btn = 1'b1;
    t0 = cyc;
    ticks(30);
    check("bounce_count", 32'(pulses), 32'd1);
    check("bounce_edge",  32'(first_pulse - t0), 32'd8);
    bus.step_btn = 1'b0;
    ticks(20);

    // Run mode: RUN at edge 8, pulses at 13, 18, 23, 28, 33.
    clear_log();
    bus.run_sw = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i == 7) check("run_pre_state",   32'(bus.state), 32'd0);
      if (i == 8) check("run_enter_state", 32'(bus.state), 32'd2);
    end
    check("run_count", 32'(pulses), 32'd5);
    check("run_first", 32'(first_pulse - t0), 32'd13);
    check("run_last",  32'(last_pulse - t0),  32'd33);

    // Leave run: one more due pulse at +4, IDLE at +8, nothing after.
    clear_log();
    bus.run_sw = 1'b0;
    t0 = cyc;
    ticks(20);
    check("run_exit_count", 32'(pulses), 32'd1);
    check("run_exit_last",  32'(last_pulse - t0), 32'd4);
    check("run_exit_state", 32'(bus.state), 32'd0);
    ticks(10);

    // Halt: Continue drops so it is sampled on the edge of the second due pulse (+18).
    clear_log();
    bus.run_sw = 1'b1;
    t0 = cyc;
    ticks(17);
    bus.cpu_continue = 1'b0;
    tick();
    check("halt_state",  32'(bus.state),  32'd3);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_pulses", 32'(pulses),     32'd1);
    for (int i = 0; i < 6; i++) begin
      bus.step_btn = ~bus.step_btn;
      bus.run_sw   = ~bus.run_sw;
      ticks(12);
    end
    bus.cpu_continue = 1'b1;
    ticks(20);
    check("halt_sticky_pulses", 32'(pulses),    32'd1);
    check("halt_sticky_state",  32'(bus.state), 32'd3);

    // Priority run over step: both levels rise together, RUN entered, first pulse at +13.
    do_reset();
    clear_log();
    t0 = cyc;
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 8) begin
        check("prio_run_state",   32'(bus.state),   32'd2);
        check("prio_run_step_en", 32'(bus.step_en), 32'd0);
      end
    end
    check("prio_first", 32'(first_pulse - t0), 32'd13);
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    ticks(20);
    check("prio_idle_state", 32'(bus.state), 32'd0);

    // Priority halt over run and step in the same IDLE cycle.
    clear_log();
    t0 = cyc;
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b1;
    ticks(7);
    check("hprio_pre_state", 32'(bus.state), 32'd0);
    bus.cpu_continue = 1'b0;
    tick();
    check("hprio_state",  32'(bus.state), 32'd3);
    check("hprio_pulses", 32'(pulses),    32'd0);

    // Reset mid-RUN with rate counter at 3, button held through release.
    do_reset();
    clear_log();
    t0 = cyc;
    bus.run_sw = 1'b1;
    ticks(11);
    check("pre_rst_state", 32'(bus.state), 32'd2);
    #2;
    reset_n      = 1'b0;
    bus.step_btn = 1'b1;
    bus.run_sw   = 1'b0;
    #1;
    check("mid_rst_state",   32'(bus.state),   32'd0);
    check("mid_rst_step_en", 32'(bus.step_en), 32'd0);
    ticks(2);
    #3 reset_n = 1'b1;
    ticks(30);
    check("held_pulses", 32'(pulses),    32'd0);
    check("held_state",  32'(bus.state), 32'd0);
    bus.step_btn = 1'b0;
    ticks(20);
    check("release_pulses", 32'(pulses), 32'd0);
    bus.step_btn = 1'b1;
    t0 = cyc;
    ticks(20);
    check("repress_count", 32'(pulses), 32'd1);
    check("repress_edge",  32'(first_pulse - t0), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
